// File: rtl/tcdm_bank_rr_arbiter.sv
// Per-bank round-robin arbiter for the TCDM log interconnect with a fixed-latency
// response-ID pipeline. Optional priority qualifier enabled by `define TCDM_ARB_PRIO_EN.

module tcdm_bank_rr_arbiter_lane #(
    parameter int unsigned PTR_W = 1,
    parameter int unsigned LANE  = 0,
    parameter int unsigned REQ_W = 1
) (
    input  logic [PTR_W-1:0] win_id,
    input  logic             hs,
    input  logic             rsp_vld,
    input  logic [PTR_W-1:0] rsp_id,
    input  logic [REQ_W-1:0] req_in,
    output logic             gnt,
    output logic             r_valid,
    output logic [REQ_W-1:0] req_sel
);

    logic sel;

    assign sel     = (win_id == PTR_W'(LANE));
    assign gnt     = sel & hs;
    assign r_valid = rsp_vld & (rsp_id == PTR_W'(LANE));
    // Zero unselected lanes so the bank mux reduces to a plain OR.
    assign req_sel = sel ? req_in : '0;

endmodule

module tcdm_bank_rr_arbiter #(
    parameter int unsigned N_MASTER       = 16,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned BE_WIDTH       = DATA_WIDTH/8,
    parameter int unsigned ADDR_MEM_WIDTH = 12,
    parameter int unsigned RESP_LAT       = 1
) (
    input  logic                                     clk_i,
    input  logic                                     rst_ni,
    input  logic [N_MASTER-1:0]                      data_req_i,
    input  logic [N_MASTER-1:0][ADDR_MEM_WIDTH-1:0]  data_add_i,
    input  logic [N_MASTER-1:0]                      data_wen_i,
    input  logic [N_MASTER-1:0][DATA_WIDTH-1:0]      data_wdata_i,
    input  logic [N_MASTER-1:0][BE_WIDTH-1:0]        data_be_i,
`ifdef TCDM_ARB_PRIO_EN
    input  logic [N_MASTER-1:0]                      prio_i,
`endif
    output logic [N_MASTER-1:0]                      data_gnt_o,
    output logic [N_MASTER-1:0]                      data_r_valid_o,
    output logic [N_MASTER-1:0][DATA_WIDTH-1:0]      data_r_rdata_o,
    output logic                                     data_req_o,
    output logic [ADDR_MEM_WIDTH-1:0]                data_add_o,
    output logic                                     data_wen_o,
    output logic [DATA_WIDTH-1:0]                    data_wdata_o,
    output logic [BE_WIDTH-1:0]                      data_be_o,
    input  logic                                     data_gnt_i,
    input  logic [DATA_WIDTH-1:0]                    data_r_rdata_i
);

    localparam int unsigned PTR_W = (N_MASTER > 1) ? $clog2(N_MASTER) : 1;

    typedef struct packed {
        logic [ADDR_MEM_WIDTH-1:0] add;
        logic                      wen;
        logic [DATA_WIDTH-1:0]     wdata;
        logic [BE_WIDTH-1:0]       be;
    } bank_req_t;

    localparam int unsigned REQ_W = $bits(bank_req_t);

    logic [PTR_W-1:0]                rr_ptr;
    logic [PTR_W-1:0]                ptr_nxt;
    logic [PTR_W-1:0]                win_id;
    logic                            found;
    logic                            hs;
    logic [N_MASTER-1:0]             cand;
    logic [N_MASTER-1:0][REQ_W-1:0]  lane_req;
    logic [N_MASTER-1:0][REQ_W-1:0]  lane_sel;
    bank_req_t                       bank_req;
    logic [RESP_LAT-1:0]             vld_pipe;
    logic [RESP_LAT-1:0][PTR_W-1:0]  id_pipe;

`ifdef TCDM_ARB_PRIO_EN
    logic [N_MASTER-1:0] prio_req;

    // Prioritised requesters narrow the candidate set; none prioritised means all compete.
    assign prio_req = data_req_i & prio_i;
    assign cand     = (|prio_req) ? prio_req : data_req_i;
`else
    assign cand = data_req_i;
`endif

    assign data_req_o = |data_req_i;
    assign hs         = data_req_o & data_gnt_i;

    // Cyclic search: first candidate at/above rr_ptr, else first candidate from 0.
    always_comb begin
        win_id = '0;
        found  = 1'b0;
        for (int i = 0; i < N_MASTER; i++) begin
            if (!found && cand[i] && (PTR_W'(i) >= rr_ptr)) begin
                win_id = PTR_W'(i);
                found  = 1'b1;
            end
        end
        for (int i = 0; i < N_MASTER; i++) begin
            if (!found && cand[i]) begin
                win_id = PTR_W'(i);
                found  = 1'b1;
            end
        end
    end

    assign ptr_nxt = (win_id == PTR_W'(N_MASTER-1)) ? '0 : win_id + PTR_W'(1);

    for (genvar l = 0; l < N_MASTER; l++) begin : g_lane
        assign lane_req[l] = {data_add_i[l], data_wen_i[l], data_wdata_i[l], data_be_i[l]};
        assign data_r_rdata_o[l] = data_r_rdata_i;

        tcdm_bank_rr_arbiter_lane #(
            .PTR_W (PTR_W),
            .LANE  (l),
            .REQ_W (REQ_W)
        ) u_lane (
            .win_id  (win_id),
            .hs      (hs),
            .rsp_vld (vld_pipe[RESP_LAT-1]),
            .rsp_id  (id_pipe[RESP_LAT-1]),
            .req_in  (lane_req[l]),
            .gnt     (data_gnt_o[l]),
            .r_valid (data_r_valid_o[l]),
            .req_sel (lane_sel[l])
        );
    end

    always_comb begin
        bank_req = '0;
        for (int i = 0; i < N_MASTER; i++) begin
            bank_req = bank_req | bank_req_t'(lane_sel[i]);
        end
    end

    assign data_add_o   = bank_req.add;
    assign data_wen_o   = bank_req.wen;
    assign data_wdata_o = bank_req.wdata;
    assign data_be_o    = bank_req.be;

    // Response tracking never stalls: the bank returns data exactly RESP_LAT cycles later.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr   <= '0;
            vld_pipe <= '0;
            id_pipe  <= '0;
        end else begin
            if (hs) rr_ptr <= ptr_nxt;
            vld_pipe[0] <= hs;
            id_pipe[0]  <= win_id;
            for (int s = 1; s < RESP_LAT; s++) begin
                vld_pipe[s] <= vld_pipe[s-1];
                id_pipe[s]  <= id_pipe[s-1];
            end
        end
    end

endmodule

// File: doc/tcdm_bank_rr_arbiter.md
# tcdm_bank_rr_arbiter

Per-bank arbiter for the TCDM logarithmic interconnect. It shares one memory bank among N_MASTER requesters with a round-robin policy. It muxes the winning request onto the bank port and tracks grant IDs through a fixed-latency response pipeline, so each read/write response reaches the master that issued it. One instance sits in front of each TCDM bank.

## Interface

Parameters:
- N_MASTER, 16, number of requesting masters (>= 1)
- DATA_WIDTH, 32, data width in bits
- BE_WIDTH, DATA_WIDTH/8, byte-enable width
- ADDR_MEM_WIDTH, 12, bank-local word address width
- RESP_LAT, 1, cycles from bank handshake to response (>= 1)

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- data_req_i  in  N_MASTER  request per master
- data_add_i  in  N_MASTER x ADDR_MEM_WIDTH  bank-local address
- data_wen_i  in  N_MASTER  0 = store, 1 = load
- data_wdata_i  in  N_MASTER x DATA_WIDTH  write data
- data_be_i  in  N_MASTER x BE_WIDTH  byte enables
- data_gnt_o  out  N_MASTER  grant, one-hot or zero
- data_r_valid_o  out  N_MASTER  response valid, one-hot or zero
- data_r_rdata_o  out  N_MASTER x DATA_WIDTH  response data, broadcast to all masters
- data_req_o  out  1  bank request
- data_add_o  out  ADDR_MEM_WIDTH  bank address
- data_wen_o  out  1  bank access type
- data_wdata_o  out  DATA_WIDTH  bank write data
- data_be_o  out  BE_WIDTH  bank byte enables
- data_gnt_i  in  1  bank grant
- data_r_rdata_i  in  DATA_WIDTH  bank read data, valid RESP_LAT cycles after handshake

## Operation

- data_req_o = OR of data_req_i.
- Winner: the first requesting master at or after rr_ptr, searching cyclically upward.
- The winner's add, wen, wdata and be drive the bank outputs. These are don't-care when data_req_o = 0.
- data_gnt_o[winner] = data_req_o & data_gnt_i. All other grant bits are 0.
- Handshake hs = data_req_o & data_gnt_i.
- rr_ptr:
  - Width is max(1, $clog2(N_MASTER)).
  - Reset value is 0.
  - On hs, rr_ptr <= (winner + 1) mod N_MASTER. Otherwise it holds.
- Response pipeline: RESP_LAT stages of {valid, id}.
  - Stage 0 loads {hs, winner} every cycle. Stages shift every cycle; there is no stall.
  - data_r_valid_o[id_last] = valid_last. All other bits are 0.
- data_r_rdata_o[i] = data_r_rdata_i for all i. No data muxing.
- Masters hold requests until granted, per the TCDM protocol. If a master withdraws before grant, the winner is re-evaluated combinationally in the same cycle.
- Boundary behaviour:
  - Pointer wraps from N_MASTER-1 to 0.
  - N_MASTER = 1: rr_ptr stays 0 and winner is always 0.
  - A response for master k and a new grant to k in the same cycle are both legal and independent.
- Reset:
  - All pipeline valid bits clear, so data_r_valid_o = 0.
  - rr_ptr is 0.
  - In-flight responses are dropped.
  - Combinational outputs follow their inputs during reset.

## Timing

- Request to grant: combinational, 0 cycles.
- Throughput: one handshake per cycle.
- Handshake in cycle t produces data_r_valid_o in cycle t + RESP_LAT, sampled with data_r_rdata_i of that cycle.
- rr_ptr updates on the clock edge following hs.
- data_gnt_i low: no grant, rr_ptr holds, nothing enters the pipeline (stage-0 valid = 0).

## Configuration

- TCDM_ARB_PRIO_EN defined:
  - Adds input port prio_i, N_MASTER wide.
  - Candidates are the requesting masters with prio_i set. If none have prio_i set, all requesting masters are candidates.
  - Round-robin from rr_ptr applies within the candidate set. The rr_ptr update rule is unchanged.
- TCDM_ARB_PRIO_EN undefined: prio_i is absent and arbitration is pure round-robin.

## Test plan

Default configuration: N_MASTER = 4, RESP_LAT = 1, TCDM_ARB_PRIO_EN undefined, unless a scenario states otherwise.

- Reset, then data_req_i = 1111 and data_gnt_i = 1 held -> data_gnt_o = 0001, 0010, 0100, 1000, 0001 on consecutive cycles; data_r_valid_o trails data_gnt_o by one cycle.
- Only master 2 requests, add 0x05A, wen 1 -> data_add_o = 0x05A, data_wen_o = 1, data_gnt_o = 0100. Next cycle: data_r_valid_o = 0100 and data_r_rdata_o[2] = data_r_rdata_i (drive 0xDEADBEEF).
- Masters 1 and 3 request, data_gnt_i = 0 for 3 cycles, then 1 -> data_gnt_o = 0000 for 3 cycles with rr_ptr held and no r_valid. Then data_gnt_o = 0010, followed by 1000.
- RESP_LAT = 3, back-to-back grants to masters 0, 1, 2 in cycles 0 to 2 -> data_r_valid_o = 0001, 0010, 0100 in cycles 3, 4, 5.
- Grant to master 1 at cycle t, rst_ni pulsed low at t+1 (RESP_LAT = 2) -> no data_r_valid_o at t+2. After reset, data_req_i = 1111 gives data_gnt_o = 0001.
- TCDM_ARB_PRIO_EN defined, rr_ptr = 0, data_req_i = 1111, prio_i = 1000 -> data_gnt_o = 1000. With prio_i = 0000 on the next request -> data_gnt_o = 0001.
